board_tile_store: RTL and testbench

//  Tile-map memory feeding vga640x480: returns the 3-bit tile code for the tile (x,y) the VGA stage requests.

---
 rtl/board_tile_store.sv | 166 ++++++++++++++++
 tb/tb_board_tile_store.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/board_tile_store.sv
// Tile-map memory for the VGA stage: self-initialising maze, req/ack tile writes, pellet tracking.
// Optional feature macro: PELLET_COUNT_EN (adds RD state, pellet_count and level_clear).
module board_tile_store #(
  parameter int GRID_W = 40,
  parameter int GRID_H = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  x,
  input  logic [5:0]  y,
  output logic [2:0]  board_data,
  input  logic        wr_req,
  output logic        wr_ready,
  input  logic [5:0]  wr_x,
  input  logic [5:0]  wr_y,
  input  logic [2:0]  wr_data,
  output logic        wr_ack,
  output logic        wr_err,
  output logic        init_done,
  output logic [11:0] pellet_count,
  output logic        level_clear
);

  localparam int N  = GRID_W * GRID_H;
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] GW_A    = AW'(GRID_W);
  localparam logic [AW-1:0] LAST    = AW'(N - 1);
  localparam logic [5:0]    XMAX    = 6'(GRID_W - 1);
  localparam logic [5:0]    YMAX    = 6'(GRID_H - 1);
  localparam logic [11:0]   CNT_MAX = 12'((N > 4095) ? 4095 : N);

  typedef enum logic [1:0] {INIT, IDLE, RD, WR} state_t;
  state_t state, state_next;

  logic [2:0]    mem [0:N-1];
  logic [AW-1:0] init_addr;
  logic [5:0]    init_x, init_y;
  logic          init_last, init_border;
  logic [AW-1:0] rd_addr, wr_addr_in, wr_addr;
  logic          rd_in_range, wr_in_range;
  logic [2:0]    wr_data_q;
  logic          wr_bad;
  logic          accept;

  // Linear addresses are computed modulo 2^AW; they are only used when in range.
  assign rd_addr     = AW'(y) * GW_A + AW'(x);
  assign wr_addr_in  = AW'(wr_y) * GW_A + AW'(wr_x);
  assign rd_in_range = (x <= XMAX) && (y <= YMAX);
  assign wr_in_range = (wr_x <= XMAX) && (wr_y <= YMAX);
  assign init_last   = (init_addr == LAST);
  assign init_border = (init_x == 6'd0) || (init_y == 6'd0) || (init_x == XMAX) || (init_y == YMAX);
  assign accept      = wr_req && (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    wr_ack     = 1'b0;
    wr_err     = 1'b0;
    case (state)
      INIT: if (init_last) state_next = IDLE;
      IDLE: begin
        wr_ready = 1'b1;
`ifdef PELLET_COUNT_EN
        if (wr_req) state_next = RD;
`else
        if (wr_req) state_next = WR;
`endif
      end
      RD: state_next = WR;
      WR: begin
        wr_ack     = 1'b1;
        wr_err     = wr_bad;
        state_next = IDLE;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_addr <= '0;
      init_x    <= '0;
      init_y    <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      init_addr <= init_addr + 1'b1;
      if (init_x == XMAX) begin
        init_x <= '0;
        init_y <= init_y + 6'd1;
      end else begin
        init_x <= init_x + 6'd1;
      end
      if (init_last) init_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr   <= '0;
      wr_data_q <= '0;
      wr_bad    <= 1'b0;
    end else if (accept) begin
      wr_addr   <= wr_addr_in;
      wr_data_q <= wr_data;
      wr_bad    <= !wr_in_range;
    end
  end

  // Gated by rst so a write caught by reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)
        mem[init_addr] <= init_border ? 3'd1 : 3'd2;
      else if (state == WR && !wr_bad)
        mem[wr_addr] <= wr_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                              board_data <= 3'd0;
    else if (state == INIT || !rd_in_range) board_data <= 3'd0;
    else                                  board_data <= mem[rd_addr];
  end

`ifdef PELLET_COUNT_EN
  logic [2:0]  old_code;
  logic [11:0] cnt_wr;

  always_ff @(posedge clk) begin
    if (rst)              old_code <= 3'd0;
    else if (state == RD) old_code <= mem[wr_addr];
  end

  always_comb begin
    cnt_wr = pellet_count;
    if (old_code == 3'd2 && wr_data_q != 3'd2 && pellet_count != 12'd0)
      cnt_wr = pellet_count - 12'd1;
    else if (old_code != 3'd2 && wr_data_q == 3'd2 && pellet_count != CNT_MAX)
      cnt_wr = pellet_count + 12'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pellet_count <= '0;
      level_clear  <= 1'b0;
    end else begin
      level_clear <= 1'b0;
      if (state == INIT && !init_border) begin
        pellet_count <= pellet_count + 12'd1;
      end else if (state == WR && !wr_bad) begin
        pellet_count <= cnt_wr;
        level_clear  <= (pellet_count == 12'd1) && (cnt_wr == 12'd0);
      end
    end
  end
`else
  assign pellet_count = '0;
  assign level_clear  = 1'b0;
`endif

endmodule

// File: tb/tb_board_tile_store.sv
// Directed bench for board_tile_store on a 4x3 grid; adapts expectations to PELLET_COUNT_EN.
module tb_board_tile_store;

`ifdef PELLET_COUNT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam int ACK_LAT = EN ? 2 : 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  x, y, wr_x, wr_y;
  logic [2:0]  board_data, wr_data;
  logic        wr_req, wr_ready, wr_ack, wr_err, init_done, level_clear;
  logic [11:0] pellet_count;

  int total  = 0;
  int passes = 0;

  board_tile_store #(.GRID_W(4), .GRID_H(3)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .board_data(board_data),
    .wr_req(wr_req), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err), .init_done(init_done),
    .pellet_count(pellet_count), .level_clear(level_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int cx, input int cy, input int e, input string tag);
    x = 6'(cx);
    y = 6'(cy);
    tick();
    chk(tag, 32'(board_data), e);
  endtask

  task automatic wait_init(input int start, input string tag);
    int n;
    n = start;
    while (!init_done && n < 100) begin
      tick();
      n++;
    end
    chk(tag, n, 12);
  endtask

  task automatic wr(input int cx, input int cy, input int d, input int e_err,
                    input int e_cnt, input int e_lc, input string tag);
    int n;
    chk({tag, "_rdy"}, 32'(wr_ready), 1);
    wr_x   = 6'(cx);
    wr_y   = 6'(cy);
    wr_data = 3'(d);
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    n = 1;
    while (!wr_ack && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, ACK_LAT);
    chk({tag, "_err"}, 32'(wr_err), e_err);
    tick();
    chk({tag, "_cnt"}, 32'(pellet_count), e_cnt);
    chk({tag, "_lc"}, 32'(level_clear), e_lc);
    chk({tag, "_ackoff"}, 32'(wr_ack), 0);
    tick();
    chk({tag, "_lc1"}, 32'(level_clear), 0);
  endtask

  initial begin
    rst = 1'b1; x = '0; y = '0; wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    tick();
    chk("rst_data",  32'(board_data), 0);
    chk("rst_rdy",   32'(wr_ready), 0);
    chk("rst_ack",   32'(wr_ack), 0);
    chk("rst_err",   32'(wr_err), 0);
    chk("rst_done",  32'(init_done), 0);
    chk("rst_cnt",   32'(pellet_count), 0);
    chk("rst_lc",    32'(level_clear), 0);

    // Requests during initialisation must be ignored.
    rst = 1'b0;
    wr_x = 6'd1; wr_y = 6'd1; wr_data = 3'd0; wr_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("init_ack", 32'(wr_ack), 0);
      chk("init_rdy", 32'(wr_ready), 0);
      chk("init_data", 32'(board_data), 0);
    end
    wr_req = 1'b0;
    wait_init(5, "init_cycles");
    chk("init_cnt", 32'(pellet_count), EN ? 2 : 0);
    chk("init_lc",  32'(level_clear), 0);

    rd(0, 0, 1, "rd_00");
    rd(1, 1, 2, "rd_11");
    rd(2, 1, 2, "rd_21");
    rd(3, 2, 1, "rd_32");
    rd(5, 0, 0, "rd_50");
    rd(1, 3, 0, "rd_13");
    rd(1, 2, 1, "rd_12");

    // Read latency: exactly one edge after the address changes.
    rd(1, 1, 2, "hold_11");
    x = 6'd0; y = 6'd1;
    #1;
    chk("lat_before", 32'(board_data), 2);
    tick();
    chk("lat_after", 32'(board_data), 1);

    wr(1, 1, 0, 0, EN ? 1 : 0, 0, "w11_0");
    rd(1, 1, 0, "rd_11_0");
    wr(2, 1, 3, 0, 0, EN ? 1 : 0, "w21_3");
    rd(2, 1, 3, "rd_21_3");
    wr(2, 1, 2, 0, EN ? 1 : 0, 0, "w21_2");
    rd(2, 1, 2, "rd_21_2");

    // Read of (1,1) coincides with its write: old value first, new value next cycle.
    x = 6'd1; y = 6'd1;
    tick();
    chk("rw_pre", 32'(board_data), 0);
    wr_x = 6'd1; wr_y = 6'd1; wr_data = 3'd2; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    repeat (ACK_LAT - 1) tick();
    chk("rw_ack", 32'(wr_ack), 1);
    tick();
    chk("rw_old", 32'(board_data), 0);
    chk("rw_cnt", 32'(pellet_count), EN ? 2 : 0);
    tick();
    chk("rw_new", 32'(board_data), 2);

    wr(4, 0, 0, 1, EN ? 2 : 0, 0, "w40_err");
    rd(0, 1, 1, "rd_01_kept");
    rd(4, 0, 0, "rd_40");

    wr(2, 1, 0, 0, EN ? 1 : 0, 0, "w21_0");
    rd(2, 1, 0, "rd_21_0");

    // Reset with a write in flight: dropped, maze and count rebuilt.
    wr_x = 6'd1; wr_y = 6'd1; wr_data = 3'd0; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
`ifdef PELLET_COUNT_EN
    chk("abort_rd_ack", 32'(wr_ack), 0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ack",  32'(wr_ack), 0);
    chk("abort_done", 32'(init_done), 0);
    chk("abort_cnt",  32'(pellet_count), 0);
    chk("abort_rdy",  32'(wr_ready), 0);
    wait_init(0, "reinit_cycles");
    chk("reinit_ack", 32'(wr_ack), 0);
    chk("reinit_cnt", 32'(pellet_count), EN ? 2 : 0);
    rd(1, 1, 2, "re_11");
    rd(2, 1, 2, "re_21");
    rd(0, 0, 1, "re_00");
    rd(3, 1, 1, "re_31");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
